// File: rtl/a_short_preamble_gen.sv
// 802.11a short training sequence source: emits NUM_REPS 16-sample STS periods
// on a valid/ready stream, with optional half-amplitude first and tail samples.
module a_short_preamble_gen #(
    parameter int I_Q_Width  = 16,
    parameter int NUM_REPS   = 10,
    parameter int WINDOW_EN  = 1,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                        CLK,
    input  logic                        s_RST_n,
    input  logic                        enable,
    input  logic                        start,
    input  logic                        out_ready,
    output logic signed [I_Q_Width-1:0] a_i,
    output logic signed [I_Q_Width-1:0] a_q,
    output logic                        output_strobe,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  dbg_state
);

    // Handshake: a sample transfers on a rising edge where output_strobe and
    // out_ready are both high; while output_strobe is high and out_ready is
    // low, a_i/a_q/output_strobe are held and no counter advances.

    typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

    localparam int              UP       = (I_Q_Width >= 16) ? I_Q_Width - 16 : 0;
    localparam int              DN       = (I_Q_Width < 16) ? 16 - I_Q_Width : 0;
    localparam logic [3:0]      LAST_REP = 4'(NUM_REPS - 1);

    state_t                      state_q, state_d;
    logic [3:0]                  idx_q, idx_d;
    logic [3:0]                  rep_q, rep_d;
    logic signed [I_Q_Width-1:0] a_i_q, a_i_d;
    logic signed [I_Q_Width-1:0] a_q_q, a_q_d;
    logic                        strobe_q, strobe_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [3:0]                  sel_idx;
    logic                        sel_half;
    logic                        handshake;

    // I component of the STS period in Q1.15; the Q component is the I
    // sequence shifted by half a period.
    function automatic logic signed [15:0] rom_i(input logic [3:0] i);
        logic signed [15:0] r;
        case (i)
            4'd0:    r = 16'sd1507;
            4'd1:    r = -16'sd4325;
            4'd2:    r = -16'sd426;
            4'd3:    r = 16'sd4686;
            4'd4:    r = 16'sd3015;
            4'd5:    r = 16'sd4686;
            4'd6:    r = -16'sd426;
            4'd7:    r = -16'sd4325;
            4'd8:    r = 16'sd1507;
            4'd9:    r = 16'sd66;
            4'd10:   r = -16'sd2589;
            4'd11:   r = -16'sd426;
            4'd12:   r = 16'sd0;
            4'd13:   r = -16'sd426;
            4'd14:   r = -16'sd2589;
            default: r = 16'sd66;
        endcase
        return r;
    endfunction

    function automatic logic signed [I_Q_Width-1:0] scale(input logic signed [15:0] r,
                                                          input logic half);
        logic signed [31:0] v;
        v = 32'(r);
        v = (v <<< UP) >>> DN;
        v = v >>> GAIN_SHIFT;
        if (half) v = v >>> 1;
        return v[I_Q_Width-1:0];
    endfunction

    assign handshake = strobe_q & out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = 4'd0;
                    rep_d   = 4'd0;
                end
            end
            RUN: begin
                if (handshake) begin
                    if (idx_q == 4'd15 && rep_q == LAST_REP) begin
                        state_d = (WINDOW_EN != 0) ? TAIL : DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd15) rep_d = rep_q + 4'd1;
                    end
                end
            end
            TAIL: begin
                if (handshake) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    // Output registers load from the next state, so a stalled RUN/TAIL state
    // recomputes exactly the sample already on the bus.
    always_comb begin
        a_i_d    = '0;
        a_q_d    = '0;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sel_idx  = idx_d;
        sel_half = (WINDOW_EN != 0) && (idx_d == 4'd0) && (rep_d == 4'd0);
        case (state_d)
            RUN, TAIL: begin
                if (state_d == TAIL) begin
                    sel_idx  = 4'd0;
                    sel_half = 1'b1;
                end
                a_i_d    = scale(rom_i(sel_idx), sel_half);
                a_q_d    = scale(rom_i(sel_idx + 4'd8), sel_half);
                strobe_d = 1'b1;
                busy_d   = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!s_RST_n) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            rep_q    <= 4'd0;
            a_i_q    <= '0;
            a_q_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            a_i_q    <= a_i_d;
            a_q_q    <= a_q_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign a_i           = a_i_q;
    assign a_q           = a_q_q;
    assign output_strobe = strobe_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_a_short_preamble_gen.sv
// Bench for a_short_preamble_gen: two configurations driven in parallel and
// compared every cycle against a burst-position model of the STS stream.
module tb_a_short_preamble_gen;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n, enable, start, out_ready;
    logic signed [W-1:0] ai[2];
    logic signed [W-1:0] aq[2];
    logic st[2];
    logic bz[2];
    logic dn[2];
    logic [1:0] dbg[2];

    always #5 clk = ~clk;

    a_short_preamble_gen #(.I_Q_Width(W), .NUM_REPS(10), .WINDOW_EN(1), .GAIN_SHIFT(0)) dut0 (
        .CLK(clk), .s_RST_n(rst_n), .enable(enable), .start(start), .out_ready(out_ready),
        .a_i(ai[0]), .a_q(aq[0]), .output_strobe(st[0]), .busy(bz[0]), .done(dn[0]),
        .dbg_state(dbg[0]));

    a_short_preamble_gen #(.I_Q_Width(W), .NUM_REPS(2), .WINDOW_EN(0), .GAIN_SHIFT(2)) dut1 (
        .CLK(clk), .s_RST_n(rst_n), .enable(enable), .start(start), .out_ready(out_ready),
        .a_i(ai[1]), .a_q(aq[1]), .output_strobe(st[1]), .busy(bz[1]), .done(dn[1]),
        .dbg_state(dbg[1]));

    int tests = 0;
    int fails = 0;

    int rom_i[16] = '{1507, -4325, -426, 4686, 3015, 4686, -426, -4325,
                      1507, 66, -2589, -426, 0, -426, -2589, 66};
    int rom_q[16] = '{1507, 66, -2589, -426, 0, -426, -2589, 66,
                      1507, -4325, -426, 4686, 3015, 4686, -426, -4325};

    int cfg_n[2] = '{10, 2};
    int cfg_w[2] = '{1, 0};
    int cfg_g[2] = '{0, 2};

    // Model: 0 idle, 1 streaming sample m_pos of the burst, 2 done pulse
    int m_phase[2] = '{0, 0};
    int m_pos[2]   = '{0, 0};
    int hs_cnt[2]  = '{0, 0};
    int done_cnt[2] = '{0, 0};

    function automatic void exp_sample(input int pos, input int n, input int win, input int gain,
                                       output int ei, output int eq);
        bit half;
        int k;
        if (pos < 16 * n) begin
            k    = pos % 16;
            half = (win != 0) && (pos == 0);
        end else begin
            k    = 0;
            half = 1'b1;
        end
        ei = rom_i[k] >>> gain;
        eq = rom_q[k] >>> gain;
        if (half) begin
            ei = ei >>> 1;
            eq = eq >>> 1;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (st[k] && out_ready) hs_cnt[k]++;
            if (dn[k]) done_cnt[k]++;
            if (!rst_n || !enable) begin
                m_phase[k] = 0;
            end else begin
                case (m_phase[k])
                    0: if (start) begin
                        m_phase[k] = 1;
                        m_pos[k]   = 0;
                    end
                    1: if (out_ready) begin
                        m_pos[k]++;
                        if (m_pos[k] == 16 * cfg_n[k] + cfg_w[k]) m_phase[k] = 2;
                    end
                    default: m_phase[k] = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            int ei, eq;
            ei = 0;
            eq = 0;
            if (m_phase[c] == 1) exp_sample(m_pos[c], cfg_n[c], cfg_w[c], cfg_g[c], ei, eq);
            check($sformatf("dut%0d a_i", c), int'(ai[c]), ei);
            check($sformatf("dut%0d a_q", c), int'(aq[c]), eq);
            check($sformatf("dut%0d strobe", c), int'(st[c]), int'(m_phase[c] == 1));
            check($sformatf("dut%0d busy", c), int'(bz[c]), int'(m_phase[c] == 1));
            check($sformatf("dut%0d done", c), int'(dn[c]), int'(m_phase[c] == 2));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            hs_cnt[k]   = 0;
            done_cnt[k] = 0;
        end
    endtask

    task automatic wait_done0(input int budget);
        int c;
        c = 0;
        while (!dn[0] && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("wait for done timeout", int'(c < budget), 1);
        cyc(2);
    endtask

    task automatic wait_pos0(input int pos, input int budget);
        int c;
        c = 0;
        while (!(m_phase[0] == 1 && m_pos[0] >= pos) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("wait for position timeout", int'(c < budget), 1);
    endtask

    initial begin
        int ei, eq;
        rst_n = 1'b0;
        enable = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;

        // Pin the model with hand-computed values
        exp_sample(0, 10, 1, 0, ei, eq);
        check("model first windowed", ei, 753);
        check("model first windowed q", eq, 753);
        exp_sample(16, 10, 1, 0, ei, eq);
        check("model sample 17", ei, 1507);
        exp_sample(160, 10, 1, 0, ei, eq);
        check("model tail", eq, 753);
        exp_sample(1, 2, 0, 2, ei, eq);
        check("model gain idx1 i", ei, -1082);
        check("model gain idx1 q", eq, 16);
        exp_sample(0, 2, 0, 2, ei, eq);
        check("model gain idx0", ei, 376);

        // Reset with start toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = ~start;
        end
        @(negedge clk);
        check("reset a_i", int'(ai[0]), 0);
        check("reset busy", int'(bz[0]), 0);
        start = 1'b0;
        rst_n = 1'b1;
        cyc(2);

        // Full burst, out_ready held high
        clear_counts();
        pulse_start();
        check("first sample dut0", int'(ai[0]), 753);
        check("first sample dut1", int'(ai[1]), 376);
        wait_done0(400);
        check("handshakes dut0", hs_cnt[0], 161);
        check("done pulses dut0", done_cnt[0], 1);
        check("handshakes dut1", hs_cnt[1], 32);
        check("done pulses dut1", done_cnt[1], 1);

        // Backpressure while idx 3 is presented
        clear_counts();
        pulse_start();
        wait_pos0(3, 20);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("held i", int'(ai[0]), 4686);
            check("held q", int'(aq[0]), -426);
            check("held strobe", int'(st[0]), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("resume i", int'(ai[0]), 3015);
        check("resume q", int'(aq[0]), 0);
        wait_done0(400);
        check("handshakes backpressure", hs_cnt[0], 161);

        // Random ready, stray starts and rare enable drops
        for (int i = 0; i < 1800; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 19) == 0);
            enable    = ($urandom_range(0, 149) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        cyc(200);

        // Abort in rep 3 after an ignored start while busy
        clear_counts();
        pulse_start();
        wait_pos0(20, 100);
        pulse_start();
        wait_pos0(50, 100);
        enable = 1'b0;
        @(negedge clk);
        check("abort a_i", int'(ai[0]), 0);
        check("abort strobe", int'(st[0]), 0);
        check("abort busy", int'(bz[0]), 0);
        enable = 1'b1;
        cyc(3);
        check("abort done count", done_cnt[0], 0);
        pulse_start();
        check("restart first i", int'(ai[0]), 753);
        check("restart first q", int'(aq[0]), 753);
        check("restart dut1", int'(ai[1]), 376);
        wait_done0(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
